// File: rtl/medidor_periodo.sv
// medidor_periodo: measures the period of a pre-synchronized wave in
// clock_FPGA cycles and holds the result under a valid/ack handshake.
// Optional feature macro: PROMEDIO_EN (average over 2^LOG2_PERIODOS periods).
module medidor_periodo #(
    parameter int ANCHO_CONTADOR = 16,
    parameter int LOG2_PERIODOS  = 2
) (
    input  logic                      clock_FPGA,
    input  logic                      reset,
    input  logic                      senial_sincronizada,
    input  logic                      iniciar,
    input  logic                      leido,
    output logic [ANCHO_CONTADOR-1:0] periodo,
    output logic                      periodo_valido,
    output logic                      desborde,
    output logic                      ocupado
);

    typedef enum logic [1:0] {
        REPOSO        = 2'd0,
        ESPERA_FLANCO = 2'd1,
        MIDIENDO      = 2'd2,
        LISTO         = 2'd3
    } estado_t;

    estado_t                   estado, estado_sig;
    logic                      previo;
    logic                      flanco;
    logic [ANCHO_CONTADOR-1:0] contador;
    logic                      contador_max;
    logic [ANCHO_CONTADOR-1:0] valor_captura;
    logic                      ultimo;

    // Decoded actions for the datapath, produced by the FSM.
    logic arranca, incrementa, reinicia_cont, acumula, captura, satura, libera;

`ifdef PROMEDIO_EN
    localparam int ACC_W = ANCHO_CONTADOR + LOG2_PERIODOS;
    localparam int NP_W  = LOG2_PERIODOS + 1;

    logic [ACC_W-1:0] acumulador;
    logic [ACC_W-1:0] suma;
    logic [NP_W-1:0]  num_periodos;

    // Truncating mean: the sum of 2^LOG2 periods always fits in ACC_W bits.
    function automatic logic [ANCHO_CONTADOR-1:0] promedio(input logic [ACC_W-1:0] s);
        logic [ACC_W-1:0] d;
        d = s >> LOG2_PERIODOS;
        return d[ANCHO_CONTADOR-1:0];
    endfunction

    assign suma          = acumulador + ACC_W'(contador);
    assign ultimo        = (num_periodos == NP_W'((1 << LOG2_PERIODOS) - 1));
    assign valor_captura = promedio(suma);
`else
    assign ultimo        = 1'b1;
    assign valor_captura = contador;
`endif

    assign flanco       = senial_sincronizada & ~previo;
    assign contador_max = (contador == {ANCHO_CONTADOR{1'b1}});

    // State register.
    always_ff @(posedge clock_FPGA or posedge reset) begin
        if (reset) estado <= REPOSO;
        else       estado <= estado_sig;
    end

    // Next-state, busy flag and datapath action decode; an edge beats saturation.
    always_comb begin
        estado_sig    = estado;
        ocupado       = 1'b0;
        arranca       = 1'b0;
        incrementa    = 1'b0;
        reinicia_cont = 1'b0;
        acumula       = 1'b0;
        captura       = 1'b0;
        satura        = 1'b0;
        libera        = 1'b0;
        case (estado)
            REPOSO: begin
                if (iniciar) begin
                    arranca    = 1'b1;
                    estado_sig = ESPERA_FLANCO;
                end
            end
            ESPERA_FLANCO: begin
                ocupado = 1'b1;
                if (flanco) begin
                    reinicia_cont = 1'b1;
                    estado_sig    = MIDIENDO;
                end else if (contador_max) begin
                    satura     = 1'b1;
                    estado_sig = LISTO;
                end else begin
                    incrementa = 1'b1;
                end
            end
            MIDIENDO: begin
                ocupado = 1'b1;
                if (flanco) begin
                    acumula = 1'b1;
                    if (ultimo) begin
                        captura    = 1'b1;
                        estado_sig = LISTO;
                    end else begin
                        reinicia_cont = 1'b1;
                    end
                end else if (contador_max) begin
                    satura     = 1'b1;
                    estado_sig = LISTO;
                end else begin
                    incrementa = 1'b1;
                end
            end
            LISTO: begin
                if (leido) begin
                    libera     = 1'b1;
                    estado_sig = REPOSO;
                end
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // Edge-detector history, period counter and held result registers.
    always_ff @(posedge clock_FPGA or posedge reset) begin
        if (reset) begin
            previo         <= 1'b1;
            contador       <= '0;
            periodo        <= '0;
            periodo_valido <= 1'b0;
            desborde       <= 1'b0;
        end else begin
            previo <= senial_sincronizada;
            if (arranca) begin
                contador <= '0;
                desborde <= 1'b0;
            end
            if (incrementa)    contador <= contador + 1'b1;
            if (reinicia_cont) contador <= {{(ANCHO_CONTADOR-1){1'b0}}, 1'b1};
            if (captura) begin
                periodo        <= valor_captura;
                periodo_valido <= 1'b1;
            end
            if (satura) begin
                periodo        <= {ANCHO_CONTADOR{1'b1}};
                desborde       <= 1'b1;
                periodo_valido <= 1'b1;
            end
            if (libera) periodo_valido <= 1'b0;
        end
    end

`ifdef PROMEDIO_EN
    // Running sum and count of completed periods for the average.
    always_ff @(posedge clock_FPGA or posedge reset) begin
        if (reset) begin
            acumulador   <= '0;
            num_periodos <= '0;
        end else if (arranca) begin
            acumulador   <= '0;
            num_periodos <= '0;
        end else if (acumula) begin
            acumulador   <= suma;
            num_periodos <= num_periodos + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_medidor_periodo.sv
// Self-checking bench for medidor_periodo (8-bit counter, LOG2_PERIODOS=2).
module tb_medidor_periodo;

    localparam int W    = 8;
    localparam int L    = 2;
    localparam int MAXC = (1 << W) - 1;
`ifdef PROMEDIO_EN
    localparam int NPER = 1 << L;
`else
    localparam int NPER = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         senial;
    logic         iniciar;
    logic         leido;
    logic [W-1:0] periodo;
    logic         periodo_valido;
    logic         desborde;
    logic         ocupado;

    int n_cmp = 0;
    int n_err = 0;

    logic w [0:1023];
    int   rises[$];
    int   last_ep;

    medidor_periodo #(.ANCHO_CONTADOR(W), .LOG2_PERIODOS(L)) dut (
        .clock_FPGA          (clk),
        .reset               (rst),
        .senial_sincronizada (senial),
        .iniciar             (iniciar),
        .leido               (leido),
        .periodo             (periodo),
        .periodo_valido      (periodo_valido),
        .desborde            (desborde),
        .ocupado             (ocupado)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic s, input logic ini, input logic lee);
        senial  = s;
        iniciar = ini;
        leido   = lee;
        @(posedge clk);
        #1;
    endtask

    // Wave: optional initial high stretch, then one pulse of random width per rise.
    task automatic build_wave(input int high0_len);
        int gap, h;
        for (int t = 0; t < 1024; t++) w[t] = 1'b0;
        for (int t = 0; t < high0_len; t++) w[t] = 1'b1;
        for (int i = 0; i < rises.size(); i++) begin
            gap = (i + 1 < rises.size()) ? rises[i+1] - rises[i] : 5;
            h   = $urandom_range(1, gap - 1);
            for (int k = 0; k < h; k++)
                if (rises[i] + k < 1024) w[rises[i] + k] = 1'b1;
        end
    endtask

    // Expected result from the wave: cycle 0 is the iniciar cycle; edges count from cycle 1.
    task automatic model(output int et, output int ep, output bit ed);
        int  limit, last, sum, n;
        bit  done;
        limit = 1 + MAXC; last = -1; sum = 0; n = 0; done = 0;
        et = -1; ep = 0; ed = 0;
        for (int t = 1; t < 1024 && !done; t++) begin
            if (t > limit) break;
            if (w[t] && !w[t-1]) begin
                if (last >= 0) begin
                    sum += t - last;
                    n++;
                end
                last  = t;
                limit = t + MAXC;
                if (n == NPER) begin
                    done = 1;
                    et   = t;
                    ep   = sum / NPER;
                end
            end
        end
        if (!done) begin
            et = limit;
            ep = MAXC;
            ed = 1;
        end
    endtask

    task automatic measure(input string name, input bit ack);
        int et, ep;
        bit ed, reached;
        model(et, ep, ed);
        last_ep = ep;
        reached = 0;
        if (et >= 1023) begin
            n_cmp++; n_err++;
            $display("FAIL %s model_range: completion cycle %0d beyond stimulus", name, et);
            return;
        end
        for (int t = 0; t <= et; t++) begin
            cyc(w[t], t == 0, 1'b0);
            if (t == 0) begin
                n_cmp++;
                if (ocupado !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s busy_start: ocupado=%b want 1", name, ocupado);
                end
            end
            if (t == et - 1) begin
                n_cmp++;
                if (periodo_valido !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s valid_early: periodo_valido=%b want 0 at cycle %0d", name, periodo_valido, t);
                end
            end
            if (t == et) begin
                reached = 1;
                n_cmp++;
                if (periodo_valido !== 1'b1 || periodo !== W'(ep) || desborde !== ed || ocupado !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s result: valido=%b periodo=%0d desborde=%b ocupado=%b want 1/%0d/%b/0",
                             name, periodo_valido, periodo, desborde, ocupado, ep, ed);
                end
            end
        end
        if (!reached) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: completion not reached", name);
        end
        if (ack) begin
            cyc(senial, 1'b0, 1'b1);
            n_cmp++;
            if (periodo_valido !== 1'b0) begin
                n_err++;
                $display("FAIL %s ack: periodo_valido=%b want 0", name, periodo_valido);
            end
            cyc(senial, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; senial = 1'b0; iniciar = 1'b0; leido = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (periodo !== '0 || periodo_valido !== 1'b0 || desborde !== 1'b0 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: periodo=%0d valido=%b desborde=%b ocupado=%b want 0/0/0/0",
                     periodo, periodo_valido, desborde, ocupado);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc(i[1], 1'b0, i[2]);
        n_cmp++;
        if (ocupado !== 1'b0 || periodo_valido !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: ocupado=%b valido=%b want 0/0", ocupado, periodo_valido);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        rises = '{3, 13, 23, 33, 43};
        build_wave(0);
        measure("single", 1'b1);
    endtask

    task automatic test_average();
        rises = '{3, 13, 25, 35, 48};
        build_wave(0);
        measure("average", 1'b1);
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 8; k++) begin
            rises = {};
            r = $urandom_range(1, 6);
            rises.push_back(r);
            for (int i = 0; i < NPER; i++) begin
                r += $urandom_range(2, (k < 4) ? 20 : 200);
                rises.push_back(r);
            end
            build_wave(0);
            measure($sformatf("random%0d", k), 1'b1);
        end
    endtask

    task automatic test_saturation();
        rises = {};
        build_wave(0);
        measure("sat_wait", 1'b1);
        rises = '{5};
        build_wave(0);
        measure("sat_measuring", 1'b1);
    endtask

    task automatic test_handshake();
        bit stable;
        int held;
        rises = '{2, 9, 16, 23, 30};
        build_wave(0);
        measure("handshake", 1'b0);
        held   = last_ep;
        stable = 1;
        for (int i = 0; i < 50; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
            if (periodo_valido !== 1'b1 || periodo !== W'(held) || ocupado !== 1'b0) stable = 0;
        end
        n_cmp++;
        if (!stable) begin
            n_err++;
            $display("FAIL hold_stable: valido=%b periodo=%0d ocupado=%b want 1/%0d/0", periodo_valido, periodo, ocupado, held);
        end
        cyc(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (periodo_valido !== 1'b0 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL ack_with_start: valido=%b ocupado=%b want 0/0", periodo_valido, ocupado);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL start_ignored: ocupado=%b want 0", ocupado);
        end
        rises = '{4, 11, 20, 26, 35};
        build_wave(0);
        measure("remeasure", 1'b1);
    endtask

    task automatic test_reset_mid();
        bit idle;
        rises = '{3, 60, 120, 180, 240};
        build_wave(0);
        for (int t = 0; t < 20; t++) cyc(w[t], t == 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (periodo !== '0 || periodo_valido !== 1'b0 || desborde !== 1'b0 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: periodo=%0d valido=%b desborde=%b ocupado=%b want 0/0/0/0",
                     periodo, periodo_valido, desborde, ocupado);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        idle = 1;
        for (int i = 0; i < 30; i++) begin
            cyc(i[2], 1'b0, i[0]);
            if (ocupado !== 1'b0 || periodo_valido !== 1'b0) idle = 0;
        end
        n_cmp++;
        if (!idle) begin
            n_err++;
            $display("FAIL reset_no_activity: ocupado=%b valido=%b want 0/0", ocupado, periodo_valido);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_high_start();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        rises = '{6, 14, 22, 30, 38};
        build_wave(4);
        measure("high_start", 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_average();
        test_random();
        test_saturation();
        test_handshake();
        test_reset_mid();
        test_high_start();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
